shift_right_serial_32: RTL



---
 rtl/shift_right_serial_32_pkg.sv | 18 +
 rtl/shift_right_serial_32_if.sv | 29 ++
 rtl/shift_right_serial_32_shift_step_right.sv | 23 ++
 rtl/shift_right_serial_32.sv | 87 ++++++++
 4 files changed

// File: rtl/shift_right_serial_32_pkg.sv
// Shared definitions for the serial right shifter: sizes, FSM states and the
// shift-op encoding that the ALU control decoder also uses.
package shift_right_serial_32_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  // Encoding of arith_i, shared with the ALU control decoder.
  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ARITH   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_serial_32_if.sv
// Request/result bus between the control unit (master) and the serial shifter (slave).
interface shift_right_serial_32_if #(
  parameter int WIDTH   = shift_right_serial_32_pkg::WIDTH,
  parameter int SHAMT_W = shift_right_serial_32_pkg::SHAMT_W
);

  // Handshake: a request (start_i with data_i/shamt_i/arith_i) is taken on a
  // rising edge only while ready_o=1; otherwise it is dropped, not queued.
  // done_o pulses for exactly one cycle and data_o holds the result from then
  // until the next accepted request.
  logic               start_i;
  logic [WIDTH-1:0]   data_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               arith_i;
  logic               ready_o;
  logic               done_o;
  logic [WIDTH-1:0]   data_o;

  modport master (
    output start_i, data_i, shamt_i, arith_i,
    input  ready_o, done_o, data_o
  );

  modport slave (
    input  start_i, data_i, shamt_i, arith_i,
    output ready_o, done_o, data_o
  );

endinterface

// File: rtl/shift_right_serial_32_shift_step_right.sv
// Combinational single-step right shifter: shifts value right by k (0..STEP)
// bits, filling the vacated top bits with fill.
module shift_step_right #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [K_W-1:0]   k,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = value;
    for (int i = 0; i < STEP; i++) begin
      if (K_W'(i) < k) begin
        shifted = {fill, shifted[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/shift_right_serial_32.sv
// Multi-cycle SRL/SRA unit: shifts right by up to STEP bits per clock until the
// requested amount is consumed, then pulses done_o for one cycle.
module shift_right_serial_32 #(
  parameter int WIDTH   = shift_right_serial_32_pkg::WIDTH,
  parameter int SHAMT_W = shift_right_serial_32_pkg::SHAMT_W,
  parameter int STEP    = 1  // 1 or 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  shift_right_serial_32_if.slave            bus,
  output shift_right_serial_32_pkg::state_t dbg_state_o
);

  import shift_right_serial_32_pkg::*;

  localparam int K_W = $clog2(STEP + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q,  data_d;
  logic [SHAMT_W-1:0] rem_q,   rem_d;
  logic               fill_q,  fill_d;

  logic [K_W-1:0]     step_k;
  logic [WIDTH-1:0]   step_out;

  // The last step of an odd amount with STEP=2 shifts by one bit only.
  assign step_k = (rem_q < SHAMT_W'(STEP)) ? rem_q[K_W-1:0] : K_W'(STEP);

  shift_step_right #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .value   (data_q),
    .k       (step_k),
    .fill    (fill_q),
    .shifted (step_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          data_d  = bus.data_i;
          rem_d   = bus.shamt_i;
          // Sign is taken once here; the shifting register is never re-read for it.
          fill_d  = (bus.arith_i == SHIFT_ARITH) & bus.data_i[WIDTH-1];
          state_d = (bus.shamt_i == '0) ? DONE : SHIFT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        data_d = step_out;
        rem_d  = rem_q - SHAMT_W'(step_k);
        if (rem_d == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready_o  = (state_q == IDLE) || (state_q == DONE);
  assign bus.done_o   = (state_q == DONE);
  assign bus.data_o   = data_q;
  assign dbg_state_o  = state_q;

endmodule
